// File: rtl/alien_shot_scheduler_if.sv
// Launcher-side bundle for the alien shot scheduler: timer tick, field status,
// missile slot status, fire request/ack handshake and timer reload period.
interface alien_shot_scheduler_if #(
  parameter int unsigned NUM_COLS  = 8,
  parameter int unsigned NUM_SLOTS = 4
);
  localparam int unsigned CW = $clog2(NUM_COLS);
  localparam int unsigned SW = $clog2(NUM_SLOTS);

  logic                 shootPulse;
  logic                 gameActive;
  logic                 levelUp;
  logic [NUM_COLS-1:0]  colAlive;
  logic [NUM_SLOTS-1:0] slotBusy;
  logic                 fireAck;
  logic [25:0]          periodOut;
  logic                 fireReq;
  logic [CW-1:0]        fireCol;
  logic [SW-1:0]        fireSlot;
  logic [7:0]           droppedCnt;

  modport slave (
    input  shootPulse, gameActive, levelUp, colAlive, slotBusy, fireAck,
    output periodOut, fireReq, fireCol, fireSlot, droppedCnt
  );

  modport master (
    output shootPulse, gameActive, levelUp, colAlive, slotBusy, fireAck,
    input  periodOut, fireReq, fireCol, fireSlot, droppedCnt
  );
endinterface

// File: rtl/alien_shot_scheduler.sv
// Alien fire sequencer: on each timer tick picks a live column (LFSR start,
// wrap search) and a free missile slot, then holds a request to the launcher.
module alien_shot_scheduler #(
  parameter int unsigned NUM_COLS    = 8,
  parameter int unsigned NUM_SLOTS   = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [25:0] BASE_PERIOD = 26'd50_000_000,
  parameter logic [25:0] PERIOD_STEP = 26'd5_000_000,
  parameter logic [25:0] MIN_PERIOD  = 26'd10_000_000
) (
  input  logic                   clk,
  input  logic                   resetN,
  alien_shot_scheduler_if.slave  bus
);
  localparam int unsigned CW = $clog2(NUM_COLS);
  localparam int unsigned SW = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, PICK, REQ} state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          fireReq_q, fireReq_d;
  logic [CW-1:0] fireCol_q, fireCol_d;
  logic [SW-1:0] fireSlot_q, fireSlot_d;
  logic [7:0]    dropped_q, dropped_d;
  logic [25:0]   period_q, period_d;

  logic          col_found, slot_found;
  logic [CW-1:0] pick_col, col_idx;
  logic [SW-1:0] pick_slot;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Column search wraps naturally through CW-bit truncation of start+k.
  always_comb begin
    col_found = 1'b0;
    pick_col  = '0;
    col_idx   = '0;
    for (int unsigned k = 0; k < NUM_COLS; k++) begin
      col_idx = lfsr_q[CW-1:0] + CW'(k);
      if (!col_found && bus.colAlive[col_idx]) begin
        col_found = 1'b1;
        pick_col  = col_idx;
      end
    end
    slot_found = 1'b0;
    pick_slot  = '0;
    for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
      if (!slot_found && !bus.slotBusy[j]) begin
        slot_found = 1'b1;
        pick_slot  = SW'(j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fireReq_d  = fireReq_q;
    fireCol_d  = fireCol_q;
    fireSlot_d = fireSlot_q;
    drop_inc   = 2'd0;
    unique case (state_q)
      IDLE: if (bus.shootPulse && bus.gameActive) state_d = PICK;
      PICK: begin
        if (bus.shootPulse) drop_inc = drop_inc + 2'd1;
        if (!col_found || !slot_found || !bus.gameActive) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = IDLE;
        end else begin
          fireCol_d  = pick_col;
          fireSlot_d = pick_slot;
          fireReq_d  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.shootPulse) drop_inc = drop_inc + 2'd1;
        if (!bus.gameActive || bus.fireAck) begin
          fireReq_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        fireReq_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    drop_sum  = {1'b0, dropped_q} + 9'(drop_inc);
    dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    period_d  = period_q;
    if (bus.levelUp)
      period_d = (period_q >= MIN_PERIOD + PERIOD_STEP) ? period_q - PERIOD_STEP : MIN_PERIOD;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      fireReq_q  <= 1'b0;
      fireCol_q  <= '0;
      fireSlot_q <= '0;
      dropped_q  <= '0;
      period_q   <= BASE_PERIOD;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      fireReq_q  <= fireReq_d;
      fireCol_q  <= fireCol_d;
      fireSlot_q <= fireSlot_d;
      dropped_q  <= dropped_d;
      period_q   <= period_d;
    end
  end

  assign bus.fireReq    = fireReq_q;
  assign bus.fireCol    = fireCol_q;
  assign bus.fireSlot   = fireSlot_q;
  assign bus.droppedCnt = dropped_q;
  assign bus.periodOut  = period_q;
endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Bench for alien_shot_scheduler: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_alien_shot_scheduler;
  localparam int NC = 8;
  localparam int NS = 4;
  localparam int BASE = 50_000_000;
  localparam int STEP = 5_000_000;
  localparam int MINP = 10_000_000;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  alien_shot_scheduler_if #(.NUM_COLS(NC), .NUM_SLOTS(NS)) bus();
  alien_shot_scheduler #(.NUM_COLS(NC), .NUM_SLOTS(NS)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pending pick flag, an outstanding-request flag, and counters.
  bit      m_pick, m_req;
  int      m_col, m_slot, m_drop, m_period;
  int unsigned m_lfsr;

  task automatic m_reset();
    m_pick = 0; m_req = 0; m_col = 0; m_slot = 0; m_drop = 0;
    m_period = BASE; m_lfsr = 16'hACE1;
  endtask

  task automatic m_step();
    int inc, start, c, s;
    if (!resetN) begin m_reset(); return; end
    inc = 0;
    if (m_pick) begin
      m_pick = 0;
      if (bus.shootPulse) inc++;
      start = m_lfsr % NC;
      c = -1;
      for (int k = 0; k < NC; k++)
        if (c < 0 && bus.colAlive[(start + k) % NC]) c = (start + k) % NC;
      s = -1;
      for (int j = NS - 1; j >= 0; j--) if (!bus.slotBusy[j]) s = j;
      if (c < 0 || s < 0 || !bus.gameActive) inc++;
      else begin m_req = 1; m_col = c; m_slot = s; end
    end else if (m_req) begin
      if (bus.shootPulse) inc++;
      if (!bus.gameActive || bus.fireAck) m_req = 0;
    end else if (bus.shootPulse && bus.gameActive) m_pick = 1;
    m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
    if (bus.levelUp) m_period = (m_period - STEP < MINP) ? MINP : m_period - STEP;
    m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr & 1) ? 32'hB400 : 32'h0);
  endtask

  task automatic cmp_all();
    chk("fireReq", 32'(bus.fireReq), 32'(m_req));
    chk("fireCol", 32'(bus.fireCol), m_col);
    chk("fireSlot", 32'(bus.fireSlot), m_slot);
    chk("droppedCnt", 32'(bus.droppedCnt), m_drop);
    chk("periodOut", 32'(bus.periodOut), m_period);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    cmp_all();
  endtask

  task automatic pulse();
    bus.shootPulse = 1'b1;
    tick();
    bus.shootPulse = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(bus.fireReq), 0);
    chk({tag, "_col"}, 32'(bus.fireCol), 0);
    chk({tag, "_slot"}, 32'(bus.fireSlot), 0);
    chk({tag, "_drop"}, 32'(bus.droppedCnt), 0);
    chk({tag, "_period"}, 32'(bus.periodOut), BASE);
  endtask

  initial begin
    resetN = 1'b0;
    bus.shootPulse = 0; bus.gameActive = 0; bus.levelUp = 0;
    bus.colAlive = '0; bus.slotBusy = '0; bus.fireAck = 0;
    m_reset();
    #12;
    chk_reset_vals("rst");
    resetN = 1'b1;

    // single live column, all slots free
    bus.gameActive = 1; bus.colAlive = 8'b0010_0000;
    tick();
    pulse();
    chk("lat_n1_req", 32'(bus.fireReq), 0);
    tick();
    chk("lat_n2_req", 32'(bus.fireReq), 1);
    chk("t1_col", 32'(bus.fireCol), 5);
    chk("t1_slot", 32'(bus.fireSlot), 0);

    // request held without ack
    repeat (10) tick();
    chk("hold_req", 32'(bus.fireReq), 1);
    chk("hold_col", 32'(bus.fireCol), 5);
    bus.fireAck = 1; tick(); bus.fireAck = 0;
    chk("ack_req", 32'(bus.fireReq), 0);

    // no free slot, then slot 2 is the lowest free
    bus.slotBusy = 4'b1111;
    pulse(); tick();
    chk("noslot_drop", 32'(bus.droppedCnt), 1);
    chk("noslot_req", 32'(bus.fireReq), 0);
    bus.slotBusy = 4'b1011;
    pulse(); tick();
    chk("slot2", 32'(bus.fireSlot), 2);
    // tick while a request is outstanding is dropped
    pulse();
    chk("req_pulse_drop", 32'(bus.droppedCnt), 2);
    bus.fireAck = 1; tick(); bus.fireAck = 0;

    // saturation with no live column
    bus.colAlive = '0; bus.slotBusy = '0;
    for (int i = 0; i < 300; i++) begin pulse(); tick(); tick(); end
    chk("sat_drop", 32'(bus.droppedCnt), 255);
    chk("sat_req", 32'(bus.fireReq), 0);

    // period ladder from reset
    resetN = 1'b0; #1; m_reset(); resetN = 1'b1;
    bus.gameActive = 0;
    for (int i = 0; i < 12; i++) begin
      bus.levelUp = 1; tick(); bus.levelUp = 0;
      chk("period", 32'(bus.periodOut), ((BASE - STEP * (i + 1)) < MINP) ? MINP : BASE - STEP * (i + 1));
    end

    // game stops during request; then reset during request
    bus.gameActive = 1; bus.colAlive = '1;
    pulse(); tick();
    chk("pre_stop_req", 32'(bus.fireReq), 1);
    bus.gameActive = 0; tick(); bus.gameActive = 1;
    chk("stop_req", 32'(bus.fireReq), 0);
    chk("stop_nodrop", 32'(bus.droppedCnt), 0);
    pulse(); tick();
    chk("pre_rst_req", 32'(bus.fireReq), 1);
    #2 resetN = 1'b0;
    #1 chk_reset_vals("async");
    m_reset();
    #2 resetN = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.shootPulse = ($urandom_range(3) == 0);
      bus.gameActive = ($urandom_range(15) != 0);
      bus.levelUp    = ($urandom_range(63) == 0);
      bus.colAlive   = ($urandom_range(7) == 0) ? '0 : NC'($urandom);
      bus.slotBusy   = NS'($urandom);
      bus.fireAck    = ($urandom_range(2) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
